// File: rtl/cpu_mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: load/store has
// priority, fetch is protected by a saturating starvation counter.
module cpu_mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] i_f_addr,
  input  logic          i_f_rd,
  output logic          o_f_wait,
  output logic [DW-1:0] o_f_rddata,
  output logic          o_f_valid,
  input  logic [AW-1:0] i_ls_addr,
  input  logic          i_ls_rd,
  input  logic          i_ls_wr,
  input  logic [DW-1:0] i_ls_wrdata,
  output logic          o_ls_wait,
  output logic [DW-1:0] o_ls_rddata,
  output logic          o_ls_valid,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [DW-1:0] o_mem_wrdata,
  input  logic [DW-1:0] i_mem_rddata
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_LS
  } owner_t;

  owner_t        owner, owner_next;
  logic [SW-1:0] starve_cnt, starve_next;
  logic          f_act, ls_act, grant_f, grant_ls;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      owner      <= owner_next;
      starve_cnt <= starve_next;
    end
  end

  always_comb begin
    f_act    = i_f_rd;
    ls_act   = i_ls_rd | i_ls_wr;
    grant_f  = f_act && (!ls_act || starve_cnt == STARVE_MAX);
    grant_ls = ls_act && !grant_f;
    o_f_wait  = f_act && !grant_f;
    o_ls_wait = ls_act && !grant_ls;

    o_mem_addr   = i_ls_addr;
    o_mem_wrdata = i_ls_wrdata;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    owner_next   = OWN_NONE;
    if (grant_f) begin
      o_mem_addr = i_f_addr;
      o_mem_rd   = 1'b1;
      owner_next = OWN_FETCH;
    end else if (grant_ls) begin
      // rd and wr together is a plain store: no read, no response
      o_mem_wr = i_ls_wr;
      o_mem_rd = !i_ls_wr;
      if (!i_ls_wr) owner_next = OWN_LS;
    end

    starve_next = '0;
    if (o_f_wait)
      starve_next = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + SW'(1);
  end

  assign o_f_valid   = (owner == OWN_FETCH);
  assign o_ls_valid  = (owner == OWN_LS);
  assign o_f_rddata  = i_mem_rddata;
  assign o_ls_rddata = i_mem_rddata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomized and directed bench for cpu_mem_arbiter against a cycle-level
// reference model with its own shadow memory.
module tb_cpu_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MAX_STARVE = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] f_addr, ls_addr, mem_addr;
  logic          f_rd, ls_rd, ls_wr;
  logic [DW-1:0] ls_wrdata, mem_wrdata, mem_rddata;
  logic          f_wait, ls_wait, f_valid, ls_valid, mem_rd, mem_wr;
  logic [DW-1:0] f_rddata, ls_rddata;

  cpu_mem_arbiter #(.AW(AW), .DW(DW), .MAX_STARVE(MAX_STARVE)) dut (
    .clk(clk), .reset(reset),
    .i_f_addr(f_addr), .i_f_rd(f_rd), .o_f_wait(f_wait),
    .o_f_rddata(f_rddata), .o_f_valid(f_valid),
    .i_ls_addr(ls_addr), .i_ls_rd(ls_rd), .i_ls_wr(ls_wr),
    .i_ls_wrdata(ls_wrdata), .o_ls_wait(ls_wait),
    .o_ls_rddata(ls_rddata), .o_ls_valid(ls_valid),
    .o_mem_addr(mem_addr), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
    .o_mem_wrdata(mem_wrdata), .i_mem_rddata(mem_rddata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory with 1-cycle read latency
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wrdata;
    if (mem_rd) mem_rddata <= mem[mem_addr];
  end

  function automatic logic [DW-1:0] init_word(input int unsigned a);
    return DW'((a * 3) ^ 32'h5A5A);
  endfunction

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  logic [DW-1:0] ref_mem [0:65535];
  int            denied;
  bit            exp_fv, exp_lv;
  logic [DW-1:0] exp_d;
  bit            acc_f, acc_ls;

  task automatic model_reset();
    denied = 0;
    exp_fv = 0;
    exp_lv = 0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit a_frd, input logic [AW-1:0] a_fa,
                      input bit a_lrd, input bit a_lwr,
                      input logic [AW-1:0] a_la, input logic [DW-1:0] a_ld);
    bit f_on, l_on, gf, gl, is_store;
    f_rd = a_frd; f_addr = a_fa; ls_rd = a_lrd; ls_wr = a_lwr;
    ls_addr = a_la; ls_wrdata = a_ld;
    #1;
    check("f_valid", f_valid, exp_fv);
    check("ls_valid", ls_valid, exp_lv);
    if (exp_fv) check("f_rddata", f_rddata, exp_d);
    if (exp_lv) check("ls_rddata", ls_rddata, exp_d);

    f_on = a_frd;
    l_on = a_lrd || a_lwr;
    is_store = a_lwr;
    gf = f_on && (!l_on || denied >= MAX_STARVE);
    gl = l_on && !gf;
    check("f_wait", f_wait, f_on && !gf);
    check("ls_wait", ls_wait, l_on && !gl);
    check("mem_rd", mem_rd, gf || (gl && !is_store));
    check("mem_wr", mem_wr, gl && is_store);
    check("mem_addr", mem_addr, gf ? a_fa : a_la);
    if (gl && is_store) check("mem_wrdata", mem_wrdata, a_ld);

    exp_fv = gf;
    exp_lv = gl && !is_store;
    if (gf) exp_d = ref_mem[a_fa];
    else if (gl && !is_store) exp_d = ref_mem[a_la];
    if (gl && is_store) ref_mem[a_la] = a_ld;
    denied = (f_on && !gf) ? ((denied < MAX_STARVE) ? denied + 1 : MAX_STARVE) : 0;
    acc_f = gf;
    acc_ls = gl;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, '0, 0, 0, '0, '0);
  endtask

  bit            r_frd, r_lrd, r_lwr;
  logic [AW-1:0] r_fa, r_la;
  logic [DW-1:0] r_ld;
  int unsigned   pick;
  int unsigned   f_grants;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    reset = 1'b0;
    f_rd = 0; f_addr = '0; ls_rd = 0; ls_wr = 0; ls_addr = '0; ls_wrdata = '0;
    model_reset();
    #1;
    check("rst_f_valid", f_valid, 0);
    check("rst_ls_valid", ls_valid, 0);
    @(negedge clk);
    reset = 1'b1;

    // fetch-only reads
    step(1, 16'h0000, 0, 0, '0, '0);
    step(1, 16'h0002, 0, 0, '0, '0);
    step(1, 16'h0004, 0, 0, '0, '0);
    idle();
    idle();

    // simultaneous fetch and load: load first, fetch next cycle
    step(1, 16'h0010, 1, 0, 16'h0100, '0);
    check("contend_ls_first", acc_ls, 1);
    step(1, 16'h0010, 0, 0, '0, '0);
    idle();
    idle();

    // continuous contention: fetch wins every MAX_STARVE+1 cycles
    f_grants = 0;
    for (int k = 0; k < 15; k++) begin
      step(1, 16'(k * 2), 1, 0, 16'(16'h0400 + k), '0);
      if (acc_f) f_grants++;
    end
    check("starve_grants", f_grants, 15 / (MAX_STARVE + 1));
    idle();
    idle();

    // store then load of the same word
    step(0, '0, 0, 1, 16'h0200, 16'hBEEF);
    step(0, '0, 1, 0, 16'h0200, '0);
    idle();
    idle();

    // rd+wr together behaves as a store
    step(0, '0, 1, 1, 16'h0300, 16'h1234);
    step(0, '0, 1, 0, 16'h0300, '0);
    idle();
    idle();

    // reset while a fetch response is in flight
    step(1, 16'h0040, 0, 0, '0, '0);
    f_rd = 0;
    #1;
    check("pre_rst_f_valid", f_valid, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_f_valid", f_valid, 0);
    check("mid_rst_ls_valid", ls_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    idle();
    idle();

    // randomized traffic; requesters hold requests until accepted
    r_frd = 0; r_lrd = 0; r_lwr = 0; r_fa = '0; r_la = '0; r_ld = '0;
    acc_f = 1; acc_ls = 1;
    for (int n = 0; n < 500; n++) begin
      if (!r_frd || acc_f) begin
        r_frd = ($urandom_range(0, 9) < 7);
        r_fa  = 16'($urandom_range(0, 63));
      end
      if (!(r_lrd || r_lwr) || acc_ls) begin
        pick  = $urandom_range(0, 9);
        r_lrd = (pick >= 3 && pick <= 5) || pick == 9;
        r_lwr = (pick >= 6);
        r_la  = 16'($urandom_range(0, 63));
        r_ld  = 16'($urandom);
      end
      step(r_frd, r_fa, r_lrd, r_lwr, r_la, r_ld);
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
